// File: rtl/codec_cmm_sad_acc.sv
// Pipelined multi-lane sum-of-absolute-differences engine: per-lane |a-b|, lane
// reduction, then per-block accumulation reported over a valid/ready handshake.
module codec_cmm_sad_acc #(
    parameter  int DW        = 8,
    parameter  int N         = 4,
    parameter  int MAX_BEATS = 16,
    localparam int SUM_W     = DW + $clog2(N),
    localparam int ACC_W     = SUM_W + $clog2(MAX_BEATS),
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              in_last,
    input  logic [N*DW-1:0]   in_a,
    input  logic [N*DW-1:0]   in_b,
    output logic              o_vld,
    input  logic              o_rdy,
    output logic [ACC_W-1:0]  o_sad,
    output logic [CNT_W-1:0]  o_beats,
    output logic              o_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    logic en;

    logic                  s1_vld;
    logic                  s1_last;
    logic [N-1:0][DW-1:0]  s1_d;
    logic [SUM_W-1:0]      s1_sum;

    logic                  s2_vld;
    logic                  s2_last;
    logic [SUM_W-1:0]      s2_sum;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_base;
    logic [ACC_W-1:0]      acc_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_base;
    logic [CNT_W-1:0]      cnt_n;
    logic                  ovf;
    logic                  ovf_n;
    logic                  first;

    // A pending, unconsumed result freezes the whole pipeline.
    assign en     = !(o_vld && !o_rdy);
    assign in_rdy = en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_d    <= '0;
        end else if (en) begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_last <= in_last;
                for (int i = 0; i < N; i++) begin
                    s1_d[i] <= (in_a[i*DW +: DW] > in_b[i*DW +: DW])
                             ? in_a[i*DW +: DW] - in_b[i*DW +: DW]
                             : in_b[i*DW +: DW] - in_a[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < N; i++) begin
            s1_sum = s1_sum + SUM_W'(s1_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_sum  <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s2_sum  <= s1_sum;
        end
    end

    // Beats past MAX_BEATS are dropped from the sum and only mark the block.
    always_comb begin
        acc_base = first ? '0 : acc;
        cnt_base = first ? '0 : cnt;
        ovf_n    = ovf;
        if (cnt_base < MAX_CNT) begin
            acc_n = acc_base + ACC_W'(s2_sum);
            cnt_n = cnt_base + CNT_W'(1);
        end else begin
            acc_n = acc;
            cnt_n = cnt;
            ovf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            first   <= 1'b1;
            o_vld   <= 1'b0;
            o_sad   <= '0;
            o_beats <= '0;
            o_ovf   <= 1'b0;
        end else if (en) begin
            if (o_rdy) begin
                o_vld <= 1'b0;
            end
            if (s2_vld) begin
                acc   <= acc_n;
                cnt   <= cnt_n;
                ovf   <= ovf_n;
                first <= 1'b0;
                if (s2_last) begin
                    o_sad   <= acc_n;
                    o_beats <= cnt_n;
                    o_ovf   <= ovf_n;
                    o_vld   <= 1'b1;
                    first   <= 1'b1;
                    ovf     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_cmm_sad_acc.sv
// Self-checking bench for codec_cmm_sad_acc: directed scenarios plus random
// blocks, scored against a block-level arithmetic model.
module tb_codec_cmm_sad_acc;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int MB    = 16;
    localparam int ACC_W = 14;
    localparam int CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld;
    logic              in_rdy;
    logic              in_last;
    logic [N*DW-1:0]   in_a;
    logic [N*DW-1:0]   in_b;
    logic              o_vld;
    logic              o_rdy;
    logic [ACC_W-1:0]  o_sad;
    logic [CNT_W-1:0]  o_beats;
    logic              o_ovf;

    typedef struct {
        int sad;
        int beats;
        int ovf;
    } res_t;

    res_t exp_q[$];
    int   out_t[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rand_rdy = 0;
    int   blk_sad = 0;
    int   blk_cnt = 0;
    int   blk_ovf = 0;

    codec_cmm_sad_acc #(.DW(DW), .N(N), .MAX_BEATS(MB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_last (in_last),
        .in_a    (in_a),
        .in_b    (in_b),
        .o_vld   (o_vld),
        .o_rdy   (o_rdy),
        .o_sad   (o_sad),
        .o_beats (o_beats),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic int beat_sum(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int x = int'(a[i*DW +: DW]);
            int y = int'(b[i*DW +: DW]);
            s += (x > y) ? x - y : y - x;
        end
        return s;
    endfunction

    // Block-level reference: sum the first MB beats, flag any extra ones.
    task automatic model_accept(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic last);
        if (blk_cnt < MB) begin
            blk_sad += beat_sum(a, b);
            blk_cnt++;
        end else begin
            blk_ovf = 1;
        end
        if (last) begin
            exp_q.push_back('{blk_sad, blk_cnt, blk_ovf});
            blk_sad = 0;
            blk_cnt = 0;
            blk_ovf = 0;
        end
    endtask

    task automatic applyStimulus(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                                 input logic last, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        @(negedge clk);
        in_vld  = 1'b1;
        in_a    = a;
        in_b    = b;
        in_last = last;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (rand_rdy) o_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (in_rdy) begin
                @(posedge clk);
                ok = 1;
                model_accept(a, b, last);
            end else begin
                waited++;
                @(negedge clk);
            end
        end
        #1 in_vld = 1'b0;
        checkOutput("beat_accepted", 64'(ok), 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld = 1'b0;
            if (rand_rdy) o_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        rand_rdy = 0;
        @(negedge clk);
        in_vld = 1'b0;
        o_rdy  = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("drain_queue_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic wait_result();
        for (int k = 0; k < 10 && !o_vld; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Scores every consumed result against the model queue.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && o_vld && o_rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 64'(o_vld), 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                checkOutput("result_sad", 64'(o_sad), 64'(e.sad));
                checkOutput("result_beats", 64'(o_beats), 64'(e.beats));
                checkOutput("result_ovf", 64'(o_ovf), 64'(e.ovf));
                out_t.push_back(cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N*DW-1:0] va, vb, ra, rb;
        int w, len;

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_a    = '0;
        in_b    = '0;
        o_rdy   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_o_vld", 64'(o_vld), 0);
        checkOutput("reset_o_sad", 64'(o_sad), 0);
        checkOutput("reset_o_beats", 64'(o_beats), 0);
        checkOutput("reset_o_ovf", 64'(o_ovf), 0);
        checkOutput("reset_in_rdy", 64'(in_rdy), 1);
        rst_n = 1'b1;

        $display("[TB] single-beat block");
        va = {8'd255, 8'd0, 8'd200, 8'd10};
        vb = {8'd0,   8'd0, 8'd100, 8'd20};
        applyStimulus(va, vb, 1'b1, w);
        @(negedge clk); #1;
        checkOutput("latency_edge1_vld", 64'(o_vld), 0);
        @(negedge clk); #1;
        checkOutput("latency_edge2_vld", 64'(o_vld), 0);
        @(negedge clk); #1;
        checkOutput("latency_edge3_vld", 64'(o_vld), 1);
        checkOutput("single_sad", 64'(o_sad), 365);
        checkOutput("single_beats", 64'(o_beats), 1);
        checkOutput("single_ovf", 64'(o_ovf), 0);
        @(negedge clk); #1;
        checkOutput("single_one_cycle", 64'(o_vld), 0);
        drain();

        $display("[TB] full block");
        for (int i = 0; i < MB; i++) applyStimulus(rep(8'd255), rep(8'd0), i == MB - 1, w);
        wait_result();
        checkOutput("full_sad", 64'(o_sad), 16320);
        checkOutput("full_beats", 64'(o_beats), 16);
        drain();

        $display("[TB] overflow block then one-beat block");
        for (int i = 0; i < MB + 1; i++) applyStimulus(rep(8'd255), rep(8'd0), i == MB, w);
        wait_result();
        checkOutput("ovf_sad", 64'(o_sad), 16320);
        checkOutput("ovf_beats", 64'(o_beats), 16);
        checkOutput("ovf_flag", 64'(o_ovf), 1);
        applyStimulus(rep(8'd7), rep(8'd8), 1'b1, w);
        @(negedge clk); #1;
        wait_result();
        checkOutput("post_ovf_sad", 64'(o_sad), 4);
        checkOutput("post_ovf_flag", 64'(o_ovf), 0);
        drain();

        $display("[TB] backpressure");
        @(negedge clk);
        o_rdy = 1'b0;
        applyStimulus(va, vb, 1'b1, w);
        wait_result();
        checkOutput("bp_pending_vld", 64'(o_vld), 1);
        ra = rnd_vec();
        rb = rnd_vec();
        @(negedge clk);
        in_vld  = 1'b1;
        in_a    = ra;
        in_b    = rb;
        in_last = 1'b0;
        repeat (4) begin
            #1;
            checkOutput("bp_in_rdy", 64'(in_rdy), 0);
            checkOutput("bp_o_sad_stable", 64'(o_sad), 365);
            checkOutput("bp_o_vld_held", 64'(o_vld), 1);
            @(negedge clk);
        end
        in_vld = 1'b0;
        o_rdy  = 1'b1;
        applyStimulus(ra, rb, 1'b0, w);
        applyStimulus(rnd_vec(), rnd_vec(), 1'b1, w);
        drain();

        $display("[TB] back-to-back two-beat blocks");
        out_t.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(rep(8'd1), rep(8'd0), 1'b0, w);
            checkOutput("b2b_no_bubble", 64'(w), 0);
            applyStimulus(rep(8'd5), rep(8'd3), 1'b1, w);
            checkOutput("b2b_no_bubble", 64'(w), 0);
        end
        drain();
        checkOutput("b2b_result_count", 64'(out_t.size()), 4);
        for (int i = 1; i < out_t.size(); i++)
            checkOutput("b2b_output_gap", 64'(out_t[i] - out_t[i-1]), 2);

        $display("[TB] random blocks with random backpressure");
        rand_rdy = 1;
        for (int blk = 0; blk < 25; blk++) begin
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                applyStimulus(rnd_vec(), rnd_vec(), j == len - 1, w);
                if ($urandom_range(0, 3) == 0) idle_cycles(1);
            end
        end
        drain();

        $display("[TB] reset mid-block");
        for (int i = 0; i < 5; i++) applyStimulus(rnd_vec(), rnd_vec(), 1'b0, w);
        @(negedge clk);
        in_vld = 1'b0;
        rst_n  = 1'b0;
        blk_sad = 0;
        blk_cnt = 0;
        blk_ovf = 0;
        exp_q.delete();
        @(negedge clk);
        #1;
        checkOutput("midreset_o_vld", 64'(o_vld), 0);
        rst_n = 1'b1;
        applyStimulus(rep(8'd10), rep(8'd13), 1'b1, w);
        @(negedge clk); #1;
        wait_result();
        checkOutput("midreset_sad", 64'(o_sad), 12);
        checkOutput("midreset_beats", 64'(o_beats), 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
